// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and
// execute-stage PC-source select values.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JAL    = 2'd2;
    localparam logic [1:0] PCSRC_JALR   = 2'd3;

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with enable and async clear.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run/halt/step controller with boot hold-off and perf counters.
// Optional PC breakpoint is enabled by defining CPU_BREAKPOINT_EN.
//
//   state | meaning
//   BOOT  | post-reset hold-off, cpu_en=0 for BOOT_CYCLES cycles
//   RUN   | free running, cpu_en=1 unless a breakpoint hits
//   HALT  | stopped, waiting for step/run request
//   STEP  | single fetch cycle with cpu_en=1, then back to HALT
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int BOOT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_req,
    input  logic            halt_req,
    input  logic            step_req,
    input  logic [PC_W-1:0] pc_f,
    input  logic [1:0]      pcsrc_ex,
    input  logic            bp_valid,
    input  logic [PC_W-1:0] bp_addr,
    output logic            cpu_en,
    output logic            flush_f,
    output logic            halted,
    output logic [1:0]      state,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instret
);

    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [BCW-1:0] boot_cnt_q, boot_cnt_d;
    logic           squash_q, squash_d;
    logic           bp_hit;

`ifdef CPU_BREAKPOINT_EN
    logic resume_q, resume_d;

    // Resume flag lets the instruction at the breakpoint PC execute once after run.
    assign bp_hit = (state_q == ST_RUN) && bp_valid && (pc_f == bp_addr) && !resume_q;

    always_comb begin
        resume_d = resume_q;
        if ((state_q == ST_HALT) && (state_d == ST_RUN)) begin
            resume_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            resume_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resume_q <= 1'b0;
        end else begin
            resume_q <= resume_d;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{bp_valid, bp_addr, pc_f};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            squash_q   <= squash_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        cpu_en     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cpu_en = !bp_hit;
                if (halt_req || bp_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_HALT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign flush_f  = cpu_en && (pcsrc_ex != PCSRC_SEQ);
    assign squash_d = cpu_en ? flush_f : squash_q;

    assign state  = state_q;
    assign halted = (state_q == ST_HALT);

    perf_counter #(.W(32)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q != ST_BOOT),
        .cnt_o (cycle_cnt)
    );

    perf_counter #(.W(32)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (cpu_en && !squash_q),
        .cnt_o (instret)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized scoreboard bench for cpu_run_ctrl against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int PC_W        = 12;
    localparam int BOOT_CYCLES = 4;
    localparam int N_CYCLES    = 3000;
`ifdef CPU_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif
    localparam logic [PC_W-1:0] BP_PC = 12'h010;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run_req, halt_req, step_req;
    logic [PC_W-1:0] pc_f;
    logic [1:0]      pcsrc_ex;
    logic            bp_valid;
    logic [PC_W-1:0] bp_addr;
    logic            cpu_en, flush_f, halted;
    logic [1:0]      state;
    logic [31:0]     cycle_cnt, instret;

    cpu_run_ctrl #(.PC_W(PC_W), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .pc_f      (pc_f),
        .pcsrc_ex  (pcsrc_ex),
        .bp_valid  (bp_valid),
        .bp_addr   (bp_addr),
        .cpu_en    (cpu_en),
        .flush_f   (flush_f),
        .halted    (halted),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        flush;
        logic        hlt;
        logic [1:0]  st;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: mode 0=BOOT 1=RUN 2=HALT 3=STEP
    int              m_mode;
    int              m_boot;
    bit              m_squash;
    bit              m_resume;
    logic [31:0]     m_cyc, m_ret;
    logic [PC_W-1:0] pc;
    int              n_hits;
    int              n_steps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_boot   = 0;
        m_squash = 0;
        m_resume = 0;
        m_cyc    = 0;
        m_ret    = 0;
        pc       = '0;
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.en = 0; e.flush = 0; e.hlt = 0; e.st = 2'd0; e.cyc = 0; e.ret = 0;
        exp_q.push_back(e);
    endtask

    task automatic model_cycle();
        exp_t e;
        bit   hit, en, fl;
        int   nm;
        hit = BP_EN && (m_mode == 1) && bp_valid && (pc_f == bp_addr) && !m_resume;
        en  = (m_mode == 3) || ((m_mode == 1) && !hit);
        fl  = en && (pcsrc_ex != 2'd0);
        if (hit) n_hits++;
        e.en = en; e.flush = fl; e.hlt = (m_mode == 2); e.st = 2'(m_mode);
        e.cyc = m_cyc; e.ret = m_ret;
        exp_q.push_back(e);

        nm = m_mode;
        case (m_mode)
            0: begin m_boot++; if (m_boot == BOOT_CYCLES) nm = 1; end
            1: if (halt_req || hit) nm = 2;
            2: if (halt_req) nm = 2; else if (step_req) nm = 3; else if (run_req) nm = 1;
            default: nm = 2;
        endcase
        if (m_mode == 3) n_steps++;
        if (m_mode != 0) m_cyc++;
        if (en && !m_squash) m_ret++;
        if (en) m_squash = fl;
        if (en) pc = pc + 1'b1;
        if (m_mode == 2 && nm == 1) m_resume = 1;
        else if (m_mode == 1) m_resume = 0;
        m_mode = nm;
    endtask

    task automatic drive_random();
        run_req  = ($urandom_range(0, 3) == 0);
        step_req = ($urandom_range(0, 3) == 0);
        halt_req = ($urandom_range(0, 7) == 0);
        pcsrc_ex = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        bp_valid = ($urandom_range(0, 7) != 0);
        bp_addr  = BP_PC;
        pc_f     = pc;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cpu_en",    {31'd0, cpu_en},  {31'd0, e.en});
                check("flush_f",   {31'd0, flush_f}, {31'd0, e.flush});
                check("halted",    {31'd0, halted},  {31'd0, e.hlt});
                check("state",     {30'd0, state},   {30'd0, e.st});
                check("cycle_cnt", cycle_cnt,        e.cyc);
                check("instret",   instret,          e.ret);
            end
        end
    end

    initial begin
        int rst_hold;
        int rst_events;
        rst_n      = 1'b0;
        run_req    = 0; halt_req = 0; step_req = 0;
        pcsrc_ex   = 0; bp_valid = 0; bp_addr = BP_PC; pc_f = 0;
        n_hits     = 0;
        n_steps    = 0;
        rst_events = 0;
        rst_hold   = 3;
        model_reset();

        for (int i = 0; i < N_CYCLES; i++) begin
            @(posedge clk);
            #1;
            if (rst_hold > 0) begin
                rst_hold--;
                drive_random();
                push_reset_exp();
            end else begin
                if (!rst_n) rst_n = 1'b1;
                drive_random();
                if (m_mode == 3 && rst_events < 3 && i > 400 * (rst_events + 1)) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_state",   {30'd0, state},   32'd0);
                    check("rst_cpu_en",  {31'd0, cpu_en},  32'd0);
                    check("rst_halted",  {31'd0, halted},  32'd0);
                    check("rst_cyc",     cycle_cnt,        32'd0);
                    check("rst_instret", instret,          32'd0);
                    model_reset();
                    push_reset_exp();
                    rst_events++;
                    rst_hold = 2;
                end else begin
                    model_cycle();
                end
            end
        end

        @(negedge clk);
        #1;
        check("queue_drain", exp_q.size(), 32'd0);
        check("reset_events_seen", (rst_events > 0) ? 32'd1 : 32'd0, 32'd1);
        check("steps_seen", (n_steps > 0) ? 32'd1 : 32'd0, 32'd1);
        if (BP_EN) check("bp_hits_seen", (n_hits > 0) ? 32'd1 : 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
